// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide controller.
//   state_e         - controller FSM state encoding
//   OP_MULT/OP_DIV  - op_sel codes
//   TIMEOUT_DEFAULT - default watchdog limit in wait cycles
//   WD_CNT_W        - watchdog counter width (covers TIMEOUT up to 255)
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MULT_WAIT = 2'd1,
        ST_DIV_WAIT  = 2'd2,
        ST_ERR       = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int WD_CNT_W        = 8;

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: wait-cycle counter with terminal-count detect.
//   clk, reset - clock, asynchronous active-low reset
//   clear      - zero the count (operation start)
//   enable     - count this cycle (controller is waiting on a unit)
//   expired    - this is the TIMEOUT-th enabled cycle since clear
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WD_CNT_W-1:0] TERM = WD_CNT_W'(TIMEOUT - 1);

    logic [WD_CNT_W-1:0] cnt_q, cnt_d;

    // Count is 0 in the first wait cycle, so TERM marks the TIMEOUT-th one.
    assign expired = enable && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences multiply/divide ops to external units and owns
// the architectural HI/LO registers.
//   op_valid/op_sel/op_a/op_b  - request from the control unit (op_sel 0=mult, 1=div)
//   flush                      - abort the in-flight op, no result, no done
//   mult_start/div_start       - one-cycle start pulses; unit_a/unit_b held operands
//   mult_done/div_done + data  - unit completion pulses and results
//   hi/lo                      - architectural registers
//   busy/done                  - stall indication / one-cycle completion pulse
//   div_zero/timeout_err       - sticky error flags, cleared on next accepted op
// Optional build macro MULDIV_DIV0_TRAP_EN: divide by zero is trapped locally
// (no div_start, div_zero set) instead of being issued to the divider.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_sel,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              mult_start,
    output logic              div_start,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    input  logic              mult_done,
    input  logic              div_done,
    input  logic [DATA_W-1:0] mult_hi,
    input  logic [DATA_W-1:0] mult_lo,
    input  logic [DATA_W-1:0] div_quot,
    input  logic [DATA_W-1:0] div_rem,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              mult_start_q, mult_start_d;
    logic              div_start_q, div_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
`ifdef MULDIV_DIV0_TRAP_EN
    logic              dz_q, dz_d;
`endif

    logic wd_clear, wd_enable, wd_expired;

    assign wd_enable = (state_q == ST_MULT_WAIT) || (state_q == ST_DIV_WAIT);

    muldiv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        a_d          = a_q;
        b_d          = b_q;
        mult_start_d = 1'b0;
        div_start_d  = 1'b0;
        done_d       = 1'b0;
        terr_d       = terr_q;
`ifdef MULDIV_DIV0_TRAP_EN
        dz_d         = dz_q;
`endif
        wd_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    terr_d   = 1'b0;
                    wd_clear = 1'b1;
`ifdef MULDIV_DIV0_TRAP_EN
                    dz_d     = 1'b0;
`endif
                    if (op_sel == OP_MULT) begin
                        state_d      = ST_MULT_WAIT;
                        mult_start_d = 1'b1;
                    end
`ifdef MULDIV_DIV0_TRAP_EN
                    else if (op_b == '0) begin
                        // Trapped divide: report through ERR, divider untouched.
                        state_d = ST_ERR;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                    end
`endif
                    else begin
                        state_d     = ST_DIV_WAIT;
                        div_start_d = 1'b1;
                    end
                end
            end

            // Priority in a wait state: flush, then unit done, then timeout
            // (a done landing on the terminal cycle still delivers its result).
            ST_MULT_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (mult_done) begin
                    hi_d    = mult_hi;
                    lo_d    = mult_lo;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    terr_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_ERR;
                end
            end

            ST_DIV_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_done) begin
                    lo_d    = div_quot;
                    hi_d    = div_rem;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    terr_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_ERR;
                end
            end

            // done was raised on entry, so it coincides with this one ERR cycle.
            ST_ERR: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            terr_q       <= terr_d;
        end
    end

`ifdef MULDIV_DIV0_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dz_q <= 1'b0;
        else
            dz_q <= dz_d;
    end
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign mult_start  = mult_start_q;
    assign div_start   = div_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule
